display_scan_controller: RTL and testbench

//   Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS digits.

---
 rtl/display_scan_controller.sv | 124 ++++++++++++
 tb/tb_display_scan_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, NUM_DIGITS digit enables.
// Words arrive via valid/ready into a shadow register and go live only at a frame boundary.
module display_scan_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 50000
) (
   input  logic                    CLOCK_50,
   input  logic                    RST,
   input  logic                    LOAD_VALID,
   output logic                    LOAD_READY,
   input  logic [4*NUM_DIGITS-1:0] LOAD_DATA,
   input  logic                    BLANK_LZ,
   output logic [3:0]              DIG_CODE,
   output logic [NUM_DIGITS-1:0]   DIG_SEL,
   output logic                    FRAME_DONE
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   shadow_q, shadow_d;
   logic            shadow_full_q, shadow_full_d;
   logic [DW-1:0]   active_q, active_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic            frame_done_q, frame_done_d;

   logic            accept;
   logic            slot_end;
   logic            boundary;
   logic [DW-1:0]   shifted;

   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         state_q       <= IDLE;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         active_q      <= '0;
         idx_q         <= '0;
         pre_q         <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         active_q      <= active_d;
         idx_q         <= idx_d;
         pre_q         <= pre_d;
         frame_done_q  <= frame_done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      active_d      = active_q;
      idx_d         = idx_q;
      pre_d         = pre_q;
      frame_done_d  = 1'b0;
      accept        = LOAD_VALID & ~shadow_full_q;
      slot_end      = (pre_q == PW'(PRESCALE - 1));
      boundary      = (state_q == SCAN) & slot_end & (idx_q == IW'(NUM_DIGITS - 1));

      case (state_q)
         IDLE: begin
            if (accept) begin
               shadow_d      = LOAD_DATA;
               shadow_full_d = 1'b1;
            end else if (shadow_full_q) begin
               active_d      = shadow_q;
               shadow_full_d = 1'b0;
               idx_d         = '0;
               pre_d         = '0;
               state_d       = SCAN;
            end
         end
         SCAN: begin
            if (slot_end) begin
               pre_d = '0;
               idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
               pre_d = pre_q + PW'(1);
            end
            // A word arriving on the boundary edge bypasses the shadow so it is never a frame late.
            if (boundary) begin
               frame_done_d = 1'b1;
               if (shadow_full_q) begin
                  active_d      = shadow_q;
                  shadow_full_d = 1'b0;
               end else if (accept) begin
                  active_d = LOAD_DATA;
               end
            end else if (accept) begin
               shadow_d      = LOAD_DATA;
               shadow_full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      DIG_SEL  = '0;
      DIG_CODE = 4'hF;
      shifted  = active_q >> (4 * idx_q);
      if (state_q == SCAN) begin
         DIG_SEL = NUM_DIGITS'(1) << idx_q;
         // Digits idx..ND-1 are all zero exactly when the shifted word is zero.
         if (BLANK_LZ && (idx_q != '0) && (shifted == '0))
            DIG_CODE = 4'hF;
         else
            DIG_CODE = shifted[3:0];
      end
   end

   assign LOAD_READY = ~shadow_full_q;
   assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a frame-time reference model.
module tb_display_scan_controller;
   localparam int ND = 4;
   localparam int P  = 4;
   localparam int FR = ND * P;
   localparam logic [9:0] RST_VEC = {4'b0000, 4'hF, 1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        rst, lv, ready, blz, fd;
   logic [15:0] data;
   logic [3:0]  code;
   logic [3:0]  sel;

   int vectors = 0;
   int errors  = 0;

   bit          m_scan, m_full, m_fd;
   int          m_t;
   logic [15:0] m_active, m_shadow;

   display_scan_controller #(.NUM_DIGITS(ND), .PRESCALE(P)) dut (
      .CLOCK_50(clk), .RST(rst), .LOAD_VALID(lv), .LOAD_READY(ready),
      .LOAD_DATA(data), .BLANK_LZ(blz), .DIG_CODE(code), .DIG_SEL(sel),
      .FRAME_DONE(fd)
   );

   always #5 clk = ~clk;

   // Expected {DIG_SEL, DIG_CODE, LOAD_READY, FRAME_DONE} from scan time m_t.
   function automatic logic [9:0] expv();
      int idx;
      bit zero;
      logic [3:0] s, c;
      s = 4'b0000;
      c = 4'hF;
      if (m_scan) begin
         idx = (m_t / P) % ND;
         s = 4'(1 << idx);
         c = m_active[4*idx +: 4];
         zero = 1'b1;
         for (int j = idx; j < ND; j++)
            if (m_active[4*j +: 4] != 4'h0) zero = 1'b0;
         if (blz && idx != 0 && zero) c = 4'hF;
      end
      return {s, c, ~m_full, m_fd};
   endfunction

   task automatic model_reset();
      m_scan = 0; m_full = 0; m_fd = 0; m_t = 0; m_active = '0; m_shadow = '0;
   endtask

   task automatic step();
      bit acc, bnd;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         acc = lv && !m_full;
         if (!m_scan) begin
            m_fd = 0;
            if (acc) begin m_shadow = data; m_full = 1; end
            else if (m_full) begin m_scan = 1; m_t = 0; m_active = m_shadow; m_full = 0; end
         end else begin
            bnd  = (m_t % FR) == FR - 1;
            m_fd = bnd;
            if (bnd) begin
               if (m_full) begin m_active = m_shadow; m_full = 0; end
               else if (acc) m_active = data;
            end else if (acc) begin
               m_shadow = data; m_full = 1;
            end
            m_t++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1; lv = 0; data = '0; blz = 0;
      model_reset();
      #1;
      repeat (20) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== RST_VEC) begin
            errors++;
            $display("FAIL reset: got %b want %b", {sel, code, ready, fd}, RST_VEC);
         end
      end
   endtask

   task automatic test_scan();
      rst = 0;
      lv = 1; data = 16'h1234;
      step();
      lv = 0;
      for (int k = 0; k < 2 * FR + 4; k++) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== expv()) begin
            errors++;
            $display("FAIL scan cyc %0d: got %b want %b", k, {sel, code, ready, fd}, expv());
         end
      end
   endtask

   task automatic test_midframe();
      for (int k = 0; k < 4 * FR && (m_t % FR) != 5; k++) step();
      vectors++;
      if ((m_t % FR) != 5) begin
         errors++;
         $display("FAIL midframe_sync: got t=%0d want t%%16=5", m_t);
      end
      lv = 1; data = 16'h5678;
      step();
      data = 16'h9999;
      repeat (3) begin
         step();
         vectors++;
         if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_ready: got %b want 0", ready);
         end
      end
      lv = 0;
      for (int k = 0; k < 2 * FR; k++) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== expv()) begin
            errors++;
            $display("FAIL midframe cyc %0d: got %b want %b", k, {sel, code, ready, fd}, expv());
         end
      end
   endtask

   task automatic test_blank();
      logic [15:0] words [3];
      bit          lzs   [3];
      words = '{16'h0050, 16'h0000, 16'h0050};
      lzs   = '{1'b1, 1'b1, 1'b0};
      for (int w = 0; w < 3; w++) begin
         blz = lzs[w];
         lv = 1; data = words[w];
         step();
         lv = 0;
         for (int k = 0; k < 2 * FR; k++) begin
            step();
            vectors++;
            if ({sel, code, ready, fd} !== expv()) begin
               errors++;
               $display("FAIL blank w%0d cyc %0d: got %b want %b", w, k, {sel, code, ready, fd}, expv());
            end
         end
      end
      blz = 0;
   endtask

   task automatic test_boundary();
      for (int k = 0; k < 4 * FR && !((m_t % FR) == FR - 1 && !m_full); k++) step();
      vectors++;
      if (!((m_t % FR) == FR - 1 && !m_full)) begin
         errors++;
         $display("FAIL boundary_sync: got t=%0d full=%0d want boundary next", m_t, m_full);
      end
      lv = 1; data = 16'hA0C9;
      step();
      lv = 0;
      vectors++;
      if ({sel, code, ready, fd} !== {4'b0001, 4'h9, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL boundary_bypass: got %b want %b", {sel, code, ready, fd}, {4'b0001, 4'h9, 1'b1, 1'b1});
      end
      for (int k = 0; k < FR + 2; k++) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== expv()) begin
            errors++;
            $display("FAIL boundary cyc %0d: got %b want %b", k, {sel, code, ready, fd}, expv());
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         lv   = ($urandom_range(7) == 0);
         data = 16'($urandom);
         if ($urandom_range(3) == 0) data = data & 16'h00FF;
         blz  = $urandom_range(1);
         step();
         vectors++;
         if ({sel, code, ready, fd} !== expv()) begin
            errors++;
            $display("FAIL random cyc %0d: got %b want %b", k, {sel, code, ready, fd}, expv());
         end
      end
      lv = 0; blz = 0;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4 * FR && (m_t % FR) != 2; k++) step();
      lv = 1; data = 16'h4321;
      step();
      lv = 0;
      for (int k = 0; k < 4 * FR && (m_t % FR) != 9; k++) step();
      vectors++;
      if (!(m_scan && m_full && (m_t % FR) == 9) || ready !== 1'b0) begin
         errors++;
         $display("FAIL resetmid_sync: got t=%0d ready=%b want t%%16=9 ready=0", m_t, ready);
      end
      #2 rst = 1;
      #1;
      vectors++;
      if ({sel, code, ready, fd} !== RST_VEC) begin
         errors++;
         $display("FAIL resetmid_async: got %b want %b", {sel, code, ready, fd}, RST_VEC);
      end
      step();
      step();
      rst = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== RST_VEC) begin
            errors++;
            $display("FAIL resetmid_idle cyc %0d: got %b want %b", k, {sel, code, ready, fd}, RST_VEC);
         end
      end
      lv = 1; data = 16'h0907;
      step();
      lv = 0;
      for (int k = 0; k < FR + 4; k++) begin
         step();
         vectors++;
         if ({sel, code, ready, fd} !== expv()) begin
            errors++;
            $display("FAIL resetmid_restart cyc %0d: got %b want %b", k, {sel, code, ready, fd}, expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_midframe();
      test_blank();
      test_boundary();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
